// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet/ARP constants, RX/TX FSM encodings and byte/CRC helpers
package eth_pkg;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
   localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   localparam int          ETH_HEAD_LEN  = 14;
   localparam int          ARP_LEN       = 28;
   typedef enum logic [4:0] {
      st_idle     = 5'b00001,
      st_preamble = 5'b00010,
      st_eth_head = 5'b00100,
      st_arp_data = 5'b01000,
      st_rx_end   = 5'b10000
   } arp_state_t;
   // Byte idx of a MAC in wire order (idx 0 = most significant byte); idx must be 0..5
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [4:0] idx);
      return 8'(mac >> (6'd40 - 6'(idx) * 6'd8));
   endfunction
   // MSB-first CRC-32 step, each byte fed LSB first as it appears on the wire
   function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLY : 32'h0);
      return c;
   endfunction
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide Ethernet CRC-32 engine, preset to all ones
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data,
   input  logic        crc_en,
   input  logic        crc_clr,
   output logic [31:0] crc_data,
   output logic [31:0] crc_next
);
   assign crc_next = crc32_d8(crc_data, data);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) crc_data <= '1;
      else if (crc_clr) crc_data <= '1;
      else if (crc_en) crc_data <= crc_next;
endmodule

// File: rtl/video_trans_eth_arp_rx.sv
// video_trans_eth_arp_rx: GMII ARP receive parser extracting peer MAC/IP and opcode.
// Define ARP_RX_FCS_CHECK_EN to gate acceptance on a good frame FCS.
module video_trans_eth_arp_rx
   import eth_pkg::*;
#(
   parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic        arp_rx_done,
   output logic        arp_rx_type,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip
);
   localparam logic [4:0] HEAD_LAST = 5'(ETH_HEAD_LEN - 1);
   localparam logic [4:0] ARP_LAST  = 5'(ARP_LEN - 1);
   arp_state_t  state, state_nxt;
   logic [4:0]  cnt;
   logic        uc_ok, bc_ok, uc_hit, bc_hit, head_ok, arp_hit, arp_match, commit;
   logic [15:0] stg_op;
   logic [47:0] stg_mac;
   logic [31:0] stg_ip, stg_tip;
`ifdef ARP_RX_FCS_CHECK_EN
   logic        pending;
   logic [31:0] crc_data;
   eth_crc32_d8 u_crc (
      .clk      (clk),
      .rst_n    (rst_n),
      .data     (gmii_rxd),
      .crc_en   (gmii_rx_dv && (state == st_eth_head || state == st_arp_data || state == st_rx_end)),
      .crc_clr  (state == st_idle),
      .crc_data (crc_data),
      .crc_next ()
   );
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= st_idle;
      else state <= state_nxt;
   always_comb begin
      uc_hit  = (cnt == 5'd0 || uc_ok) && gmii_rxd == mac_byte(BOARD_MAC, cnt);
      bc_hit  = (cnt == 5'd0 || bc_ok) && gmii_rxd == 8'hFF;
      head_ok = cnt < 5'd6   ? (uc_hit || bc_hit) :
                cnt == 5'd12 ? gmii_rxd == ETH_TYPE_ARP[15:8] :
                cnt == 5'd13 ? gmii_rxd == ETH_TYPE_ARP[7:0] : 1'b1;
      arp_hit = {stg_tip[23:0], gmii_rxd} == BOARD_IP && (stg_op == ARP_OP_REQ || stg_op == ARP_OP_REPLY);
      state_nxt = st_idle;
      case (state)
         st_idle:     state_nxt = gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE ? st_preamble : st_idle;
         st_preamble: state_nxt = !gmii_rx_dv ? st_idle :
                                  cnt == 5'd7 && gmii_rxd == SFD_BYTE ? st_eth_head :
                                  cnt < 5'd7 && gmii_rxd == PREAMBLE_BYTE ? st_preamble : st_rx_end;
         st_eth_head: state_nxt = !gmii_rx_dv ? st_idle : !head_ok ? st_rx_end :
                                  cnt == HEAD_LAST ? st_arp_data : st_eth_head;
         st_arp_data: state_nxt = !gmii_rx_dv ? st_idle : cnt == ARP_LAST ? st_rx_end : st_arp_data;
         st_rx_end:   state_nxt = gmii_rx_dv ? st_rx_end : st_idle;
         default:     state_nxt = st_idle;
      endcase
   end
   always_comb begin
      arp_match = state == st_arp_data && gmii_rx_dv && cnt == ARP_LAST && arp_hit;
`ifdef ARP_RX_FCS_CHECK_EN
      commit = state == st_rx_end && !gmii_rx_dv && pending && crc_data == CRC_RESIDUE;
`else
      commit = arp_match;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         uc_ok       <= 1'b0;
         bc_ok       <= 1'b0;
         stg_op      <= '0;
         stg_mac     <= '0;
         stg_ip      <= '0;
         stg_tip     <= '0;
         arp_rx_done <= 1'b0;
         arp_rx_type <= 1'b0;
         src_mac     <= '0;
         src_ip      <= '0;
      end else begin
         // staying in a parse state implies dv=1, so every stay counts one byte
         cnt <= state_nxt != state ? (state_nxt == st_preamble ? 5'd1 : 5'd0) :
                (state == st_idle || state == st_rx_end) ? cnt : cnt + 5'd1;
         if (state == st_eth_head && cnt < 5'd6) begin
            uc_ok <= uc_hit;
            bc_ok <= bc_hit;
         end
         if (state == st_arp_data && gmii_rx_dv) begin
            if (cnt == 5'd6 || cnt == 5'd7) stg_op <= {stg_op[7:0], gmii_rxd};
            if (cnt >= 5'd8 && cnt <= 5'd13) stg_mac <= {stg_mac[39:0], gmii_rxd};
            if (cnt >= 5'd14 && cnt <= 5'd17) stg_ip <= {stg_ip[23:0], gmii_rxd};
            if (cnt >= 5'd24) stg_tip <= {stg_tip[23:0], gmii_rxd};
         end
         arp_rx_done <= commit;
         if (commit) begin
            src_mac     <= stg_mac;
            src_ip      <= stg_ip;
            arp_rx_type <= stg_op == ARP_OP_REPLY;
         end
      end
   end
`ifdef ARP_RX_FCS_CHECK_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pending <= 1'b0;
      else pending <= state == st_idle ? 1'b0 : arp_match ? 1'b1 : pending;
`endif
endmodule

// File: tb/tb_video_trans_eth_arp_rx.sv
// tb_video_trans_eth_arp_rx: directed ARP frames with hand-built expectations.
// Define ARP_RX_FCS_CHECK_EN to exercise the FCS-gated variant.
module tb_video_trans_eth_arp_rx;
   import eth_pkg::*;
   localparam logic [47:0] BMAC  = 48'h001122334455;
   localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
   localparam logic [31:0] BIP   = 32'hC0A8010A;
   localparam logic [47:0] PC_MAC = 48'h000A3501FEC0;
   localparam logic [31:0] PC_IP  = 32'hC0A80166;
   logic clk = 1'b0, rst_n = 1'b0, gmii_rx_dv = 1'b0;
   logic [7:0] gmii_rxd = 8'h00;
   logic arp_rx_done, arp_rx_type;
   logic [47:0] src_mac;
   logic [31:0] src_ip;
   int total = 0, bad = 0, cyc = 0, pulses = 0, done_cyc = -1, mark_cyc = -1, fall_cyc = -1, p0 = 0;
   logic [7:0] frm[$];
   video_trans_eth_arp_rx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .gmii_rx_dv  (gmii_rx_dv),
      .gmii_rxd    (gmii_rxd),
      .arp_rx_done (arp_rx_done),
      .arp_rx_type (arp_rx_type),
      .src_mac     (src_mac),
      .src_ip      (src_ip)
   );
   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (arp_rx_done) begin pulses++; done_cyc = cyc; end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic build(input int npre, input logic [47:0] dst, input logic [15:0] etype,
                        input logic [15:0] op, input logic [47:0] smac, input logic [31:0] sip,
                        input logic [31:0] tip);
      logic [7:0] pl[$];
      logic [31:0] crc;
      frm = {};
      pl = {};
      repeat (npre) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) pl.push_back(dst[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) pl.push_back(smac[i*8 +: 8]);
      pl.push_back(etype[15:8]); pl.push_back(etype[7:0]);
      pl.push_back(8'h00); pl.push_back(8'h01); pl.push_back(8'h08); pl.push_back(8'h00);
      pl.push_back(8'h06); pl.push_back(8'h04);
      pl.push_back(op[15:8]); pl.push_back(op[7:0]);
      for (int i = 5; i >= 0; i--) pl.push_back(smac[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) pl.push_back(sip[i*8 +: 8]);
      repeat (6) pl.push_back(8'h00);
      for (int i = 3; i >= 0; i--) pl.push_back(tip[i*8 +: 8]);
      repeat (18) pl.push_back(8'h00);
      crc = 32'hFFFFFFFF;
      foreach (pl[i]) begin
         crc ^= {24'h0, pl[i]};
         for (int b = 0; b < 8; b++) crc = crc[0] ? (crc >> 1) ^ 32'hEDB88320 : crc >> 1;
      end
      crc = ~crc;
      for (int i = 0; i < 4; i++) pl.push_back(crc[i*8 +: 8]);
      frm = {frm, pl};
   endtask
   task automatic send(input int n, input int mark);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         gmii_rx_dv = 1'b1;
         gmii_rxd = frm[i];
         if (i == mark) mark_cyc = cyc;
      end
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rxd = 8'h00;
      fall_cyc = cyc;
   endtask
   task automatic settle();
      repeat (4) @(negedge clk);
   endtask
   task automatic frame_ok(input string tag, input logic typ, input logic [47:0] mac, input logic [31:0] ip);
      p0 = pulses;
      send(frm.size(), 49);
      settle();
      check({tag, "_pulses"}, 64'(pulses - p0), 64'd1);
`ifdef ARP_RX_FCS_CHECK_EN
      check({tag, "_when"}, 64'(done_cyc), 64'(fall_cyc + 1));
`else
      check({tag, "_when"}, 64'(done_cyc), 64'(mark_cyc + 1));
`endif
      check({tag, "_type"}, 64'(arp_rx_type), 64'(typ));
      check({tag, "_mac"}, 64'(src_mac), 64'(mac));
      check({tag, "_ip"}, 64'(src_ip), 64'(ip));
   endtask
   task automatic frame_rej(input string tag, input logic [47:0] mac);
      p0 = pulses;
      send(frm.size(), -1);
      settle();
      check({tag, "_pulses"}, 64'(pulses - p0), 64'd0);
      check({tag, "_mac"}, 64'(src_mac), 64'(mac));
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_done", 64'(arp_rx_done), 64'd0);
      check("rst_type", 64'(arp_rx_type), 64'd0);
      check("rst_mac", 64'(src_mac), 64'd0);
      check("rst_ip", 64'(src_ip), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      build(7, BCAST, 16'h0806, 16'h0001, PC_MAC, PC_IP, BIP);
      frame_ok("bcast_req", 1'b0, PC_MAC, PC_IP);
      build(7, BMAC, 16'h0806, 16'h0002, 48'h000A3501FEC1, 32'hC0A80167, BIP);
      frame_ok("ucast_reply", 1'b1, 48'h000A3501FEC1, 32'hC0A80167);
      repeat (10) @(negedge clk);
      check("hold_type", 64'(arp_rx_type), 64'd1);
      check("hold_mac", 64'(src_mac), 64'h000A3501FEC1);
      check("hold_ip", 64'(src_ip), 64'hC0A80167);
      build(7, BCAST, 16'h0806, 16'h0001, PC_MAC, PC_IP, 32'hC0A8010B);
      frame_rej("wrong_ip", 48'h000A3501FEC1);
      build(7, BCAST, 16'h0800, 16'h0001, PC_MAC, PC_IP, BIP);
      frame_rej("wrong_etype", 48'h000A3501FEC1);
      build(7, 48'h001122334456, 16'h0806, 16'h0001, PC_MAC, PC_IP, BIP);
      frame_rej("wrong_dst", 48'h000A3501FEC1);
      build(7, BMAC, 16'h0806, 16'h0003, PC_MAC, PC_IP, BIP);
      frame_rej("bad_opcode", 48'h000A3501FEC1);
      check("rej_ip_held", 64'(src_ip), 64'hC0A80167);
      // early SFD, then a good frame after a single idle cycle
      p0 = pulses;
      build(5, BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC2, 32'hC0A80168, BIP);
      send(frm.size(), -1);
      build(7, BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC3, 32'hC0A80169, BIP);
      send(frm.size(), 49);
      settle();
      check("short_pre_pulses", 64'(pulses - p0), 64'd1);
      check("short_pre_mac", 64'(src_mac), 64'h000A3501FEC3);
      check("short_pre_ip", 64'(src_ip), 64'hC0A80169);
      // back-to-back good frames
      p0 = pulses;
      build(7, BMAC, 16'h0806, 16'h0002, 48'h000A3501FEC4, 32'hC0A8016A, BIP);
      send(frm.size(), 49);
      build(7, BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC5, 32'hC0A8016B, BIP);
      send(frm.size(), 49);
      settle();
      check("b2b_pulses", 64'(pulses - p0), 64'd2);
      check("b2b_type", 64'(arp_rx_type), 64'd0);
      check("b2b_mac", 64'(src_mac), 64'h000A3501FEC5);
      // dv drops at ARP byte 20
      p0 = pulses;
      build(7, BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC6, 32'hC0A8016C, BIP);
      send(8 + 14 + 20, -1);
      settle();
      check("dv_drop_pulses", 64'(pulses - p0), 64'd0);
      check("dv_drop_mac", 64'(src_mac), 64'h000A3501FEC5);
      // reset in the middle of a frame
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         gmii_rx_dv = 1'b1;
         gmii_rxd = frm[i];
      end
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      gmii_rx_dv = 1'b0;
      check("midrst_done", 64'(arp_rx_done), 64'd0);
      check("midrst_type", 64'(arp_rx_type), 64'd0);
      check("midrst_mac", 64'(src_mac), 64'd0);
      check("midrst_ip", 64'(src_ip), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      build(7, BMAC, 16'h0806, 16'h0002, PC_MAC, PC_IP, BIP);
      frame_ok("post_rst", 1'b1, PC_MAC, PC_IP);
`ifdef ARP_RX_FCS_CHECK_EN
      build(7, BCAST, 16'h0806, 16'h0001, 48'h000A3501FEC7, 32'hC0A8016D, BIP);
      frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
      frame_rej("bad_fcs", PC_MAC);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
